// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MUL / UMULH / SMULH.
// Retires one multiplier bit per cycle. Result is the selected half of the 2*WIDTH product.
module seq_multiplier #(
  parameter int WIDTH = 64
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] BusA,
  input  logic [WIDTH-1:0] BusB,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [CW-1:0]        r_count;
  logic [1:0]           r_op;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_a;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_result;

  logic                 w_accept;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_acc_next;

  // Magnitude of a two's-complement operand; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] f_abs(input logic signed [WIDTH-1:0] v);
    logic [WIDTH-1:0] u;
    u = v;
    return u[WIDTH-1] ? (~u + 1'b1) : u;
  endfunction

  function automatic logic [2*WIDTH-1:0] f_apply_sign(input logic [2*WIDTH-1:0] p,
                                                      input logic neg);
    return neg ? (~p + 1'b1) : p;
  endfunction

  function automatic logic [WIDTH-1:0] f_select(input logic [1:0] op,
                                                input logic [2*WIDTH-1:0] p);
    return (op == 2'b01 || op == 2'b10) ? p[2*WIDTH-1:WIDTH] : p[WIDTH-1:0];
  endfunction

  assign Ready    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign Busy     = (r_state == S_CALC);
  assign Done     = (r_state == S_DONE);
  assign Result   = r_result;
  assign w_accept = Start & Ready;
  assign w_last   = (r_count == CW'(WIDTH - 1));

  // Add the multiplicand into the upper half when the current multiplier bit is set,
  // then shift the whole accumulator right, keeping the carry out of the add.
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
  assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (Start) w_state_next = S_CALC;
      S_CALC:  if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = Start ? S_CALC : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_a      <= '0;
      r_op     <= 2'b00;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (w_accept) begin
      r_op    <= Op;
      r_count <= '0;
      if (Op == 2'b10) begin
        r_a   <= f_abs(BusA);
        r_acc <= {{WIDTH{1'b0}}, f_abs(BusB)};
        r_neg <= BusA[WIDTH-1] ^ BusB[WIDTH-1];
      end else begin
        r_a   <= BusA;
        r_acc <= {{WIDTH{1'b0}}, BusB};
        r_neg <= 1'b0;
      end
    end else if (r_state == S_CALC) begin
      r_acc   <= w_acc_next;
      r_count <= r_count + 1'b1;
      if (w_last) r_result <= f_select(r_op, f_apply_sign(w_acc_next, r_neg));
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed cases plus randomized operations
// compared against a plain 128-bit arithmetic reference.
module tb_seq_multiplier;
  localparam int W = 64;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] BusA, BusB;
  logic         Ready, Busy, Done;
  logic [W-1:0] Result;

  int n_pass  = 0;
  int n_total = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .BusA(BusA), .BusB(BusB),
    .Ready(Ready), .Busy(Busy), .Done(Done), .Result(Result)
  );

  always #5 Clk = ~Clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [1:0] op);
    logic        [2*W-1:0] up;
    logic signed [2*W-1:0] sa, sb, sp;
    up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sa = {{W{a[W-1]}}, a};
    sb = {{W{b[W-1]}}, b};
    sp = sa * sb;
    case (op)
      2'b01:   return up[2*W-1:W];
      2'b10:   return sp[2*W-1:W];
      default: return up[W-1:0];
    endcase
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one operation; optionally keep Start asserted with fresh operands for 'hold' cycles.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op,
                       input int hold, output logic [W-1:0] res, output int lat,
                       output int busy_n, output logic [W-1:0] held);
    @(negedge Clk);
    BusA = a; BusB = b; Op = op; Start = 1'b1;
    @(posedge Clk); #1;
    held   = Result;
    busy_n = 0;
    lat    = -1;
    for (int n = 0; n < 200; n++) begin
      if (n > 0) begin @(posedge Clk); #1; end
      if (n >= hold) Start = 1'b0;
      else begin BusA = rnd64(); BusB = rnd64(); Op = 2'($urandom_range(0, 3)); end
      if (Done) begin lat = n; break; end
      if (Busy) busy_n++;
    end
    Start = 1'b0;
    res = Result;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Start = 1'b1; Op = 2'b00; BusA = 64'd9; BusB = 64'd9;
    repeat (2) @(posedge Clk);
    #1;
    n_total++; if (Result !== 64'd0) $display("FAIL reset_result got %h exp 0", Result); else n_pass++;
    n_total++; if (Done !== 1'b0) $display("FAIL reset_done got %b exp 0", Done); else n_pass++;
    n_total++; if (Ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", Ready); else n_pass++;
    n_total++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", Busy); else n_pass++;
    @(negedge Clk);
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clk); #1;
    n_total++; if (Ready !== 1'b1 || Busy !== 1'b0)
      $display("FAIL reset_idle got ready=%b busy=%b exp 1/0", Ready, Busy); else n_pass++;
  endtask

  task automatic test_mul();
    logic [W-1:0] res, held;
    int lat, busy_n;
    do_op(64'd7, 64'd6, 2'b00, 0, res, lat, busy_n, held);
    n_total++; if (res !== 64'd42) $display("FAIL mul_7x6 got %0d exp 42", res); else n_pass++;
    n_total++; if (lat !== W) $display("FAIL mul_latency got %0d exp %0d", lat, W); else n_pass++;
    n_total++; if (busy_n !== W) $display("FAIL mul_busy_cycles got %0d exp %0d", busy_n, W); else n_pass++;
    @(posedge Clk); #1;
    n_total++; if (Done !== 1'b0 || Ready !== 1'b1)
      $display("FAIL done_pulse got done=%b ready=%b exp 0/1", Done, Ready); else n_pass++;
    n_total++; if (Result !== 64'd42) $display("FAIL result_hold got %0d exp 42", Result); else n_pass++;
  endtask

  task automatic test_umulh();
    logic [W-1:0] res, held;
    int lat, busy_n;
    do_op('1, '1, 2'b01, 0, res, lat, busy_n, held);
    n_total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE)
      $display("FAIL umulh_max got %h exp fffffffffffffffe", res); else n_pass++;
    do_op('1, '1, 2'b00, 0, res, lat, busy_n, held);
    n_total++; if (res !== 64'd1) $display("FAIL mul_max got %h exp 1", res); else n_pass++;
  endtask

  task automatic test_smulh();
    logic [W-1:0] res, held;
    int lat, busy_n;
    do_op(-64'sd3, 64'd5, 2'b10, 0, res, lat, busy_n, held);
    n_total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL smulh_m3x5 got %h exp ffffffffffffffff", res); else n_pass++;
    do_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b10, 0, res, lat, busy_n, held);
    n_total++; if (res !== 64'h4000_0000_0000_0000)
      $display("FAIL smulh_minmin got %h exp 4000000000000000", res); else n_pass++;
    n_total++; if (lat !== W) $display("FAIL smulh_latency got %0d exp %0d", lat, W); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] res1, res2, held;
    logic [W-1:0] a1, b1, a2, b2;
    int lat, busy_n;
    a1 = rnd64(); b1 = rnd64(); a2 = rnd64(); b2 = rnd64();
    do_op(a1, b1, 2'b01, 10, res1, lat, busy_n, held);
    n_total++; if (res1 !== model(a1, b1, 2'b01))
      $display("FAIL start_ignored_busy got %h exp %h", res1, model(a1, b1, 2'b01)); else n_pass++;
    // Called right away: the next negedge is still inside the DONE cycle.
    do_op(a2, b2, 2'b10, 0, res2, lat, busy_n, held);
    n_total++; if (held !== res1)
      $display("FAIL b2b_result_kept got %h exp %h", held, res1); else n_pass++;
    n_total++; if (lat !== W) $display("FAIL b2b_latency got %0d exp %0d", lat, W); else n_pass++;
    n_total++; if (res2 !== model(a2, b2, 2'b10))
      $display("FAIL b2b_result got %h exp %h", res2, model(a2, b2, 2'b10)); else n_pass++;
  endtask

  task automatic test_abort();
    logic [W-1:0] res, held;
    int lat, busy_n, done_seen;
    @(negedge Clk);
    BusA = 64'd123; BusB = 64'd456; Op = 2'b00; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (29) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk); #1;
    n_total++; if (Result !== 64'd0 || Ready !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0)
      $display("FAIL abort_state got res=%h rdy=%b busy=%b done=%b exp 0/1/0/0",
               Result, Ready, Busy, Done); else n_pass++;
    @(negedge Clk);
    Reset = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge Clk); #1;
      if (Done) done_seen++;
    end
    n_total++; if (done_seen !== 0) $display("FAIL abort_no_done got %0d exp 0", done_seen); else n_pass++;
    do_op(64'd2, 64'd3, 2'b00, 0, res, lat, busy_n, held);
    n_total++; if (res !== 64'd6) $display("FAIL after_abort got %0d exp 6", res); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] res, held, a, b, exp_v;
    logic [1:0] op;
    int lat, busy_n;
    for (int i = 0; i < 12; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 64'd0;
        1:       a = 64'h8000_0000_0000_0000;
        default: a = rnd64();
      endcase
      b = (i % 4 == 3) ? -64'sd1 : rnd64();
      exp_v = model(a, b, op);
      do_op(a, b, op, 0, res, lat, busy_n, held);
      n_total++; if (res !== exp_v || lat !== W)
        $display("FAIL random_%0d op=%0d got %h lat=%0d exp %h lat=%0d", i, op, res, lat, exp_v, W);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_umulh();
    test_smulh();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
